encoder_frame_tx: RTL and testbench
===================================

# encoder_frame_tx

Transmit-side frame packer feeding the rx-decoder FIFO path, in the `clk_dp` domain. It drains 64-bit payload words from an upstream standard-read FIFO in fixed-length frames of `FRAME_WORDS` words. It applies the lane reorder that the decoder output path undoes, writes the words to the downstream FIFO with full-flag backpressure, and enforces an idle gap between frames.

## Interface
Parameters:
- `FRAME_WORDS`, 260: words per frame; legal range 1..2047.
- `GAP_CYCLES`, 16: idle cycles after each frame; 0 is legal and means no gap.

Ports:
- `clk_dp`, in, 1: the only clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `en`, in, 1: level enable; sampled only in `IDLE`.
- `src_empty`, in, 1: upstream FIFO empty.
- `src_rden`, out, 1: upstream read strobe.
- `src_dout`, in, 64: upstream data, valid the cycle after `src_rden`.
- `dst_full`, in, 1: downstream FIFO full.
- `dst_wren`, out, 1: downstream write strobe.
- `dst_din`, out, 64: downstream write data.
- `busy`, out, 1: high in every state except `IDLE`.
- `frame_done`, out, 1: one-cycle pulse when the last word of a frame is written.
- `frame_cnt`, out, 16: count of completed frames; wraps from 0xFFFF to 0.

## Operation
- State machine with states `IDLE`, `BURST`, `DRAIN`, `GAP`.
  - `IDLE` → `BURST` when `en` is high and `src_empty` is low.
  - `BURST` → `DRAIN` when the read counter reaches `FRAME_WORDS`.
  - `DRAIN` → `GAP` on the cycle the last word is written. If `GAP_CYCLES` = 0, go straight to `IDLE` instead.
  - `GAP` → `IDLE` after `GAP_CYCLES` cycles.
- Read side:
  - `src_rden` = state is `BURST` AND !`src_empty` AND reads issued < `FRAME_WORDS` AND (skid occupancy + reads in flight) < 2.
  - Reads in flight are 0 or 1.
- Skid buffer:
  - 2 entries, FIFO order.
  - A word returned from the source (the registered `src_rden`) is always accepted; it can never overflow by construction.
- Write side:
  - Each cycle the head entry is written when skid is non-empty AND !`dst_full`.
  - `dst_wren`/`dst_din` are registered outputs.
  - `dst_wren` is never asserted while `dst_full` was high in the previous cycle's sample.
  - `dst_din` holds its last value when `dst_wren` is low.
- Counters:
  - 11-bit read counter and 11-bit write counter, both cleared on entry to `BURST`.
  - The frame ends when the write counter reaches `FRAME_WORDS`.
- Source underflow mid-frame: stall in `BURST`; no padding words are inserted.
- `en` dropping mid-frame: the frame completes; `en` is ignored until `IDLE`.
- Output ordering: words leave in source order; a frame's words are never interleaved with another frame's.

## Timing
- Reset values: `src_rden` 0, `dst_wren` 0, `dst_din` 0, `busy` 0, `frame_done` 0, `frame_cnt` 0, state `IDLE`, skid empty.
- Reset mid-frame: all of the above apply on the next edge. An in-flight source word is discarded, so the upstream FIFO loses it; this is accepted.
- Minimum latency: `src_rden` at cycle t → `dst_wren` at t+2.
- Sustained throughput: 1 word/cycle while `src_empty` and `dst_full` stay low.
- Full frame with no stalls: `FRAME_WORDS` + 2 cycles from the first `src_rden` to `frame_done`.
- `frame_done` coincides with the final `dst_wren`. `frame_cnt` increments on the same edge that registers `frame_done`.
- `dst_full` asserted with 2 skid entries held: `src_rden` stays low until an entry drains.
- The first `src_rden` of a frame is the cycle after the `IDLE`→`BURST` transition.

## Configuration
- Macro: `ENC_LANE_REORDER_EN`.
- Defined: output byte b (0..7) = input byte b XOR 4, bit-reversed within the byte, i.e. `dst_din[8b+j]` = word[8(b^4)+7-j]. This is an involution and matches the decoder-side output mapping.
- Undefined: `dst_din` = the word unchanged.
- Control timing is identical in both builds.

## Test plan
- Reorder: with the macro defined, word 0x0000000000000001 → `dst_din` 0x0000008000000000. With it undefined, the word passes through unchanged.
- Full frame: `FRAME_WORDS`=260, source preloaded with 300 words, `dst_full`=0.
  - Exactly 260 writes, in order, on consecutive cycles.
  - `frame_done` is a single pulse and `frame_cnt`=1.
  - Then `GAP_CYCLES`=16 cycles with no `src_rden`; the next frame starts after that.
- Backpressure: hold `dst_full` high for 10 cycles mid-frame.
  - No write occurs during the hold and no word is lost or duplicated.
  - `src_rden` is low once the skid holds 2 entries.
- Underflow: supply 100 words, then 5 empty cycles, then 160 words. Result is 260 writes, `frame_done` once, and no zero padding.
- Reset mid-frame: assert `rst` at write 50.
  - All outputs go to 0 the next cycle and the state is `IDLE`.
  - The next frame writes a full 260 words.
- Wrap: force `frame_cnt` to 0xFFFF, complete one frame, and check `frame_cnt` = 0x0000.

Source files
------------

// File: rtl/encoder_frame_tx.sv
// encoder_frame_tx
// Transmit-side frame packer in the clk_dp domain. Drains 64-bit words from an
// upstream standard-read FIFO in frames of FRAME_WORDS words. It passes them through a
// 2-entry skid buffer and writes them to the downstream FIFO under full-flag backpressure.
// An idle gap of GAP_CYCLES cycles follows each frame.
//
// Build option: define ENC_LANE_REORDER_EN to apply the byte-lane reorder that the
// decoder output path undoes. Output byte b takes input byte b^4 with its bits reversed.
// When the macro is undefined, words pass through unchanged.
//
// Ports:
//   clk_dp      clock
//   rst         synchronous active-high reset
//   en          level enable, sampled only while idle
//   src_empty   upstream FIFO empty
//   src_rden    upstream read strobe (data returns the next cycle)
//   src_dout    upstream read data
//   dst_full    downstream FIFO full
//   dst_wren    downstream write strobe (registered)
//   dst_din     downstream write data (registered, holds when no write)
//   busy        high whenever not idle
//   frame_done  one-cycle pulse with the last write of a frame
//   frame_cnt   completed-frame counter, wraps at 16 bits
module encoder_frame_tx #(
  parameter int unsigned FRAME_WORDS = 260,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic        clk_dp,
  input  logic        rst,
  input  logic        en,
  input  logic        src_empty,
  output logic        src_rden,
  input  logic [63:0] src_dout,
  input  logic        dst_full,
  output logic        dst_wren,
  output logic [63:0] dst_din,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam logic [10:0] FrameLen  = 11'(FRAME_WORDS);
  localparam logic [10:0] FrameLast = 11'(FRAME_WORDS - 1);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StDrain, StGap} state_e;

  state_e          state_q;
  logic [10:0]     rd_cnt_q, wr_cnt_q;
  logic [GapW-1:0] gap_cnt_q;
  logic            inflight_q;
  logic [63:0]     skid0_q, skid1_q;
  logic [1:0]      skid_cnt_q;
  logic            dst_wren_q, busy_q, frame_done_q;
  logic [63:0]     dst_din_q;
  logic [15:0]     frame_cnt_q;

  logic        have_word, pop, pop_skid, push, push_slot, last_wr;
  logic [63:0] head;

  function automatic logic [63:0] lane_map(input logic [63:0] w);
    logic [63:0] r;
`ifdef ENC_LANE_REORDER_EN
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 8; j++) begin
        r[8*b+j] = w[8*(b^4)+7-j];
      end
    end
`else
    r = w;
`endif
    return r;
  endfunction

  // At most one read is outstanding, and a read is issued only when the skid has room
  // for it, so the returning word can always be accepted.
  assign src_rden = (state_q == StBurst) && !src_empty && (rd_cnt_q < FrameLen) &&
                    ((skid_cnt_q + {1'b0, inflight_q}) < 2'd2);

  // An empty skid lets the returning word bypass straight to the output register.
  // This bypass is what gives the two-cycle read-to-write latency.
  assign have_word = (skid_cnt_q != 2'd0) || inflight_q;
  assign pop       = have_word && !dst_full;
  assign pop_skid  = pop && (skid_cnt_q != 2'd0);
  assign head      = (skid_cnt_q != 2'd0) ? skid0_q : src_dout;
  assign push      = inflight_q && !(pop && (skid_cnt_q == 2'd0));
  assign push_slot = (skid_cnt_q == 2'd1) && !pop_skid;
  assign last_wr   = pop && (wr_cnt_q == FrameLast);

  always_ff @(posedge clk_dp) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      skid0_q      <= '0;
      skid1_q      <= '0;
      skid_cnt_q   <= '0;
      dst_wren_q   <= 1'b0;
      dst_din_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      inflight_q <= src_rden;

      if (pop_skid) skid0_q <= skid1_q;
      if (push) begin
        if (push_slot) skid1_q <= src_dout;
        else           skid0_q <= src_dout;
      end
      skid_cnt_q <= skid_cnt_q + {1'b0, push} - {1'b0, pop_skid};

      dst_wren_q <= pop;
      if (pop) begin
        dst_din_q <= lane_map(head);
        wr_cnt_q  <= wr_cnt_q + 11'd1;
      end
      frame_done_q <= last_wr;
      if (last_wr) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (src_rden) rd_cnt_q <= rd_cnt_q + 11'd1;

      unique case (state_q)
        StIdle: begin
          if (en && !src_empty) begin
            state_q  <= StBurst;
            busy_q   <= 1'b1;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
          end
        end
        StBurst: begin
          if (src_rden && (rd_cnt_q == FrameLast)) state_q <= StDrain;
        end
        StDrain: begin
          if (last_wr) begin
            if (GAP_CYCLES == 0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= StGap;
              gap_cnt_q <= '0;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dst_wren   = dst_wren_q;
  assign dst_din    = dst_din_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_encoder_frame_tx.sv
// Bench for encoder_frame_tx: an upstream FIFO model feeds the DUT and a scoreboard
// queue holds the expected output words, pushed as each source word is handed over.
module tb_encoder_frame_tx;

  localparam int unsigned FW  = 260;
  localparam int unsigned GAP = 16;

  logic        clk_dp = 1'b0;
  logic        rst, en, src_empty, src_rden, dst_full, dst_wren, busy, frame_done;
  logic [63:0] src_dout, dst_din;
  logic [15:0] frame_cnt;

  always #5 clk_dp = ~clk_dp;

  encoder_frame_tx #(.FRAME_WORDS(FW), .GAP_CYCLES(GAP)) dut (
    .clk_dp    (clk_dp),
    .rst       (rst),
    .en        (en),
    .src_empty (src_empty),
    .src_rden  (src_rden),
    .src_dout  (src_dout),
    .dst_full  (dst_full),
    .dst_wren  (dst_wren),
    .dst_din   (dst_din),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt)
  );

  int n_tests = 0, n_fail = 0;
  logic [63:0] src_q[$];
  logic [63:0] exp_q[$];
  bit   full_req, en_req, rst_req, rd_seen;
  int   cyc = 0, n_wr = 0, wr_frame = 0, n_done = 0, n_rd = 0, n_pop = 0, rd_win = 0;
  int   first_rd = -1, first_wr = -1, done_cyc = -1, last_wr_cyc = -1, wr_gap = 0;
  int   wr_after_full = 0, hold_err = 0, rd_when_empty = 0;
  int   w0, r0, rd_hold, wr_hold, pop0;
  logic [63:0] last_din = '0, first_din = '0;
  logic [31:0] seq = 32'd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_map(input logic [63:0] w);
`ifdef ENC_LANE_REORDER_EN
    logic [63:0] r;
    logic [7:0]  byte_v;
    for (int b = 0; b < 8; b++) begin
      byte_v = w[8*(b^4) +: 8];
      for (int j = 0; j < 8; j++) r[8*b+j] = byte_v[7-j];
    end
    return r;
`else
    return w;
`endif
  endfunction

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      seq = seq + 32'd1;
      src_q.push_back({~seq, seq});
    end
  endtask

  // One clock: observe at the falling edge, drive inputs, then model the source
  // FIFO returning data just after the rising edge.
  task automatic step();
    @(negedge clk_dp);
    cyc++;
    if (dst_wren) begin
      if (dst_full) wr_after_full++;
      if (first_wr < 0) begin
        first_wr  = cyc;
        first_din = dst_din;
      end
      if (wr_frame != 0 && last_wr_cyc != cyc - 1) wr_gap++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) check("sb_extra_wr", 64'(dst_wren), 64'd0);
      else check("wr_data", dst_din, exp_q.pop_front());
      wr_frame++;
      n_wr++;
      last_din = dst_din;
    end else if (dst_din !== last_din) begin
      hold_err++;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
      check("done_on_wr", 64'(dst_wren), 64'd1);
      check("frame_len", 64'(wr_frame), 64'(FW));
      wr_frame = 0;
    end
    src_empty = (src_q.size() == 0);
    dst_full  = full_req;
    en        = en_req;
    rst       = rst_req;
    #1;
    rd_seen = src_rden;
    if (rd_seen) begin
      n_rd++;
      rd_win++;
      if (first_rd < 0) first_rd = cyc;
      if (src_empty) rd_when_empty++;
    end
    @(posedge clk_dp);
    #1;
    if (rd_seen && src_q.size() != 0) begin
      src_dout = src_q.pop_front();
      exp_q.push_back(ref_map(src_dout));
      n_pop++;
    end else begin
      src_dout = 64'hBAD0_BAD0_BAD0_BAD0;
    end
  endtask

  task automatic wait_done(input int k, input string tag);
    for (int i = 0; i < 2000 && n_done < k; i++) step();
    check(tag, 64'(n_done), 64'(k));
  endtask

  task automatic wait_busy(input logic v, input string tag);
    for (int i = 0; i < 200 && busy !== v; i++) step();
    check(tag, 64'(busy), 64'(v));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rden"},  64'(src_rden),   64'd0);
    check({tag, "_wren"},  64'(dst_wren),   64'd0);
    check({tag, "_din"},   dst_din,         64'd0);
    check({tag, "_busy"},  64'(busy),       64'd0);
    check({tag, "_done"},  64'(frame_done), 64'd0);
    check({tag, "_fcnt"},  64'(frame_cnt),  64'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; src_empty = 1'b1; dst_full = 1'b0; src_dout = '0;
    rst_req = 1'b1; en_req = 1'b0; full_req = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_req = 1'b0;
    step();

    // Full frame with a free-running source and sink; first word exercises the mapping.
    src_q.push_back(64'h1);
    fill(299);
    en_req = 1'b1;
    wait_done(1, "f1_done_timeout");
`ifdef ENC_LANE_REORDER_EN
    check("reorder_w1", first_din, 64'h0000_0080_0000_0000);
`else
    check("reorder_w1", first_din, 64'h1);
`endif
    check("f1_writes", 64'(n_wr), 64'(FW));
    check("f1_reads", 64'(n_pop), 64'(FW));
    check("f1_latency", 64'(first_wr - first_rd), 64'd2);
    // FRAME_WORDS + 2 cycles counted inclusively from first read to frame_done.
    check("f1_frame_time", 64'(done_cyc - first_rd), 64'(FW + 1));
    check("f1_consecutive", 64'(wr_gap), 64'd0);
    check("f1_frame_cnt", 64'(frame_cnt), 64'd1);
    fill(260);
    rd_win = 0;
    repeat (GAP) step();
    check("gap_no_rden", 64'(rd_win), 64'd0);
    check("single_done", 64'(n_done), 64'd1);
    for (int i = 0; i < 10 && rd_win == 0; i++) step();
    check("f2_starts", 64'(rd_win != 0), 64'd1);

    // Backpressure mid-frame, with en dropped while the frame runs.
    en_req = 1'b0;
    for (int i = 0; i < 400 && wr_frame < 100; i++) step();
    check("bp_reach_100", 64'(wr_frame), 64'd100);
    full_req = 1'b1;
    rd_hold = 0;
    wr_hold = 0;
    for (int k = 0; k < 10; k++) begin
      w0 = n_wr;
      r0 = n_rd;
      step();
      if (k >= 1 && n_wr != w0) wr_hold++;
      if (k >= 2 && n_rd != r0) rd_hold++;
    end
    full_req = 1'b0;
    check("bp_no_write", 64'(wr_hold), 64'd0);
    check("bp_rden_low", 64'(rd_hold), 64'd0);
    wait_done(2, "f2_done_timeout");
    check("f2_frame_cnt", 64'(frame_cnt), 64'd2);
    wait_busy(1'b0, "f2_idle");
    check("f2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Source underflow: 100 words, five empty cycles, then 160 more.
    src_q.delete();
    pop0 = n_pop;
    fill(100);
    en_req = 1'b1;
    wait_busy(1'b1, "uf_start");
    en_req = 1'b0;
    for (int i = 0; i < 400 && n_pop < pop0 + 100; i++) step();
    check("uf_first_100", 64'(n_pop - pop0), 64'd100);
    repeat (5) step();
    fill(160);
    wait_done(3, "uf_done_timeout");
    check("uf_reads", 64'(n_pop - pop0), 64'(FW));
    check("uf_sb_empty", 64'(exp_q.size()), 64'd0);
    wait_busy(1'b0, "uf_idle");
    check("uf_single_done", 64'(n_done), 64'd3);

    // Reset at write 50; the words read but not yet written are discarded.
    fill(400);
    en_req = 1'b1;
    for (int i = 0; i < 400 && wr_frame < 50; i++) step();
    check("rst_reach_50", 64'(wr_frame), 64'd50);
    rst_req = 1'b1;
    step();
    check_reset_outputs("midrst");
    rst_req = 1'b0;
    exp_q.delete();
    wr_frame = 0;
    last_din = '0;
    wait_busy(1'b1, "rst_restart");
    en_req = 1'b0;
    wait_done(4, "rst_done_timeout");
    check("rst_frame_cnt", 64'(frame_cnt), 64'd1);
    wait_busy(1'b0, "rst_idle");

    // Frame counter wrap.
    dut.frame_cnt_q = 16'hFFFF;
    fill(260);
    en_req = 1'b1;
    wait_busy(1'b1, "wrap_start");
    en_req = 1'b0;
    wait_done(5, "wrap_done_timeout");
    check("wrap_frame_cnt", 64'(frame_cnt), 64'd0);
    wait_busy(1'b0, "wrap_idle");

    check("no_wr_after_full", 64'(wr_after_full), 64'd0);
    check("din_hold", 64'(hold_err), 64'd0);
    check("no_rd_when_empty", 64'(rd_when_empty), 64'd0);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
